// File: rtl/sipo.sv
// UART-style serial-in parallel-out receiver, oversampled by baud_clk.
// Start bit sampled mid-bit; data LSB first, optional parity, one stop bit.
module sipo #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       baud_clk,
  input  logic       reset,
  input  logic       data_tx,
  input  logic [1:0] parity_type,
  output logic [7:0] data_out,
  output logic       active_flag,
  output logic       done_flag,
  output logic       parity_error,
  output logic       stop_error
);

  localparam int CW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    sr;
  logic [1:0]    ptype_q;
  logic          perr_q;
  logic          s1, s2, rx_q;
  logic          rx_s;

  assign rx_s = s2;

  always_ff @(posedge baud_clk or posedge reset) begin
    if (reset) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      rx_q <= 1'b1;
    end else begin
      s1   <= data_tx;
      s2   <= s1;
      rx_q <= s2;
    end
  end

  always_ff @(posedge baud_clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      idx          <= '0;
      sr           <= '0;
      ptype_q      <= '0;
      perr_q       <= 1'b0;
      data_out     <= '0;
      active_flag  <= 1'b0;
      done_flag    <= 1'b0;
      parity_error <= 1'b0;
      stop_error   <= 1'b0;
    end else begin
      done_flag <= 1'b0;
      unique case (state)
        IDLE: begin
          // Edge, not level: a line stuck low never starts a frame.
          if (rx_q && !rx_s) begin
            state       <= START;
            cnt         <= '0;
            idx         <= '0;
            perr_q      <= 1'b0;
            ptype_q     <= parity_type;
            active_flag <= 1'b1;
          end
        end
        START: begin
          if (cnt == HALF) begin
            cnt <= '0;
            if (!rx_s) begin
              state <= DATA;
            end else begin
              state       <= IDLE;
              active_flag <= 1'b0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == LAST) begin
            cnt <= '0;
            sr  <= {rx_s, sr[7:1]};
            idx <= idx + 3'd1;
            if (idx == 3'd7) begin
              if (ptype_q == 2'b01 || ptype_q == 2'b10)
                state <= PARITY;
              else
                state <= STOP;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        PARITY: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= STOP;
            if (ptype_q == 2'b01)
              perr_q <= ~(^{sr, rx_s});
            else
              perr_q <= ^{sr, rx_s};
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (cnt == LAST) begin
            cnt          <= '0;
            state        <= IDLE;
            active_flag  <= 1'b0;
            data_out     <= sr;
            parity_error <= perr_q;
            stop_error   <= ~rx_s;
            done_flag    <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state       <= IDLE;
          active_flag <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/sipo.md
SIPO -- requirements
Module: sipo

Interface
REQ-001 SHALL provide parameter OVERSAMPLE, default 16, sampling ticks per bit; legal values are even and at least 4.
REQ-002 SHALL provide baud_clk  input  1  sampling clock at OVERSAMPLE x bit rate; the sole clock.
REQ-003 SHALL provide reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide data_tx  input  1  serial line driven by the upstream PISO; idle high; asynchronous to baud_clk.
REQ-005 SHALL provide parity_type  input  2  00 none, 01 odd, 10 even, 11 none.
REQ-006 SHALL provide data_out  output  8  last received data byte.
REQ-007 SHALL provide active_flag  output  1  high while a frame is being received.
REQ-008 SHALL provide done_flag  output  1  one-cycle pulse when a frame completes.
REQ-009 SHALL provide parity_error  output  1  parity mismatch on the last frame.
REQ-010 SHALL provide stop_error  output  1  stop bit sampled low on the last frame.

Function
REQ-011 SHALL accept frames of 1 start bit (0), 8 data bits LSB first, 1 parity bit when parity_type is 01 or 10, and 1 stop bit (1).
REQ-012 SHALL pass data_tx through a 2-flop synchronizer; all logic uses the synchronized value rx_s.
REQ-013 SHALL implement states IDLE, START, DATA, PARITY, STOP, with a tick counter (0..OVERSAMPLE-1) and a bit index (0..7).
REQ-014 IDLE: on a 1->0 transition of rx_s, SHALL enter START, clear the counter and latch parity_type; a line held low SHALL NOT start a frame.
REQ-015 START: at counter == OVERSAMPLE/2-1 SHALL sample rx_s; if 0, go to DATA with counter cleared; if 1, treat as a false start and return to IDLE with no flags raised.
REQ-016 DATA: at counter == OVERSAMPLE-1 SHALL shift rx_s into the shift register MSB (shift right), clear the counter and increment the bit index; after the 8th bit, go to PARITY if the latched type is 01/10, else STOP.
REQ-017 PARITY: at counter == OVERSAMPLE-1 SHALL sample the parity bit p; the error is ^{data,p}==0 for odd and ^{data,p}==1 for even.
REQ-018 STOP: at counter == OVERSAMPLE-1 SHALL sample rx_s and return to IDLE.
REQ-019 On the stop sample cycle+1 SHALL load data_out, parity_error (0 when no parity) and stop_error (= ~stop sample) together, and pulse done_flag for exactly one cycle.
REQ-020 data_out, parity_error and stop_error SHALL hold their values until the next done_flag.
REQ-021 SHALL deliver a frame with a stop error normally, with data_out updated and done_flag pulsed.
REQ-022 active_flag SHALL be high in START, DATA, PARITY and STOP, and low in IDLE.
REQ-023 SHALL ignore changes to parity_type in mid-frame; the value latched in REQ-014 applies.
REQ-024 SHALL place each sample mid-bit: the counter is cleared only at start detect and at each bit sample, with no re-synchronization inside the frame.

Reset
REQ-025 While reset is high, SHALL force IDLE, counters 0, synchronizer flops 1, data_out 8'h00, and active_flag, done_flag, parity_error and stop_error 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no done_flag; after release, reception resumes only on a new 1->0 transition.

Verification
V-1 Reset then idle line high -> all outputs 0, active_flag 0, no done_flag.
V-2 parity_type=00, frame 8'b01001010 -> done_flag single pulse, data_out=8'h4A, parity_error=0, stop_error=0; active_flag high for 9.5 bit times plus synchronizer delay.
V-3 parity_type=01 with p=0, then parity_type=10 with p=1, each with data 8'h4A -> parity_error=0 both; the same frames with p inverted -> parity_error=1 and data_out=8'h4A.
V-4 Low glitch shorter than OVERSAMPLE/2-2 ticks -> false start, return to IDLE, no done_flag, data_out unchanged.
V-5 Stop bit driven 0 and line held low -> done_flag, stop_error=1, then no new frame until the line returns high and falls again.
V-6 Reset pulse in DATA at bit 4 -> active_flag 0 immediately, no done_flag; the next full frame 8'h5A is received correctly.
